// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port, synchronous-read memory between
// instruction fetch and load/store. Data has priority; a bounded-wait counter
// forces a fetch grant after MAX_WAIT consecutive denied fetch cycles.
// Read data returns one cycle after the grant, tagged to the issuing requester.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    // instruction fetch path
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_WIDTH-1:0] if_rdata,
    // load/store path
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    // shared memory port
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam logic [3:0] LP_MAX_WAIT = 4'(MAX_WAIT);

    logic [3:0] r_wait_cnt;
    logic       r_rsp_if;
    logic       r_rsp_d;

    logic       w_fetch_forced;
    logic       w_if_win;
    logic       w_d_win;

    // Arbitration: data wins unless fetch has waited MAX_WAIT cycles.
    // Reset is folded in so no grant is visible while reset_n is low.
    always_comb begin
        w_fetch_forced = (r_wait_cnt == LP_MAX_WAIT);
        w_if_win       = reset_n & if_req & (~d_req | w_fetch_forced);
        w_d_win        = reset_n & d_req & ~w_if_win;
    end

    // Memory port drive from the winner; zeros when nobody is granted.
    always_comb begin
        if_gnt    = w_if_win;
        d_gnt     = w_d_win;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_if_win) begin
            mem_addr = if_addr;
        end else if (w_d_win) begin
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end
    end

    // Starvation counter: counts consecutive denied fetch cycles, saturating.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wait_cnt <= '0;
        end else if (!if_req || w_if_win) begin
            r_wait_cnt <= '0;
        end else if (r_wait_cnt < LP_MAX_WAIT) begin
            r_wait_cnt <= r_wait_cnt + 4'd1;
        end
    end

    // Response tags: remember which requester owns next cycle's mem_rdata.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rsp_if <= 1'b0;
            r_rsp_d  <= 1'b0;
        end else begin
            r_rsp_if <= w_if_win;
            r_rsp_d  <= w_d_win & ~d_we;
        end
    end

    // Steer returning read data to its owner; the other side sees zero.
    always_comb begin
        if_rvalid = r_rsp_if;
        d_rvalid  = r_rsp_d;
        if_rdata  = r_rsp_if ? mem_rdata : '0;
        d_rdata   = r_rsp_d  ? mem_rdata : '0;
    end

endmodule
